// File: rtl/keypad_scanner_if.sv
// Key FIFO side of the keypad scan core.
//   master : the bus wrapper, which pops codes and clears the overflow flag
//   slave  : the scan core, which presents the FIFO head, level, overflow and irq
// Ports carried:
//   key_code   FIFO head, row*4 + col
//   key_valid  FIFO not empty
//   key_pop    pop request for the FIFO head
//   fifo_level number of queued codes
//   overflow   sticky dropped-press flag
//   ovf_clr    clears overflow
//   irq        level interrupt, follows key_valid
interface keypad_scanner_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       key_code;
    logic             key_valid;
    logic             key_pop;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             ovf_clr;
    logic             irq;

    modport master (
        input  key_code, key_valid, fifo_level, overflow, irq,
        output key_pop, ovf_clr
    );

    modport slave (
        output key_code, key_valid, fifo_level, overflow, irq,
        input  key_pop, ovf_clr
    );
endinterface

// File: rtl/keypad_scanner.sv
// Scan core for a 4x4 matrix keypad.
// Drives one row low at a time, samples the columns at the end of each row dwell,
// debounces whole-matrix snapshots, converts new presses into 4-bit codes and
// queues them in a small FIFO.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-low
//   columnas keypad columns, active-low, asynchronous to clk
//   filas    keypad rows, active-low one-hot drive
//   kp       FIFO side (head code, valid, level, overflow, irq, pop, overflow clear)
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 5,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      columnas,
    output logic [3:0]      filas,
    keypad_scanner_if.slave kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE_CNT);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [DIV_W-1:0] dwell_cnt;
    logic [1:0]       row;
    logic             scan_done;
    logic [15:0]      snapshot;
    logic [15:0]      prev_snapshot;
    logic [15:0]      stable;
    logic [15:0]      pending;
    logic [3:0]       stable_cnt;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             ovf;

    logic        dwell_end;
    logic [1:0]  row_nxt;
    logic [15:0] pending_low;
    logic [3:0]  push_code;
    logic        push;
    logic        pop;
    logic        full;
    logic        do_write;
    logic [3:0]  stable_cnt_nxt;
    logic        accept;

    assign dwell_end = (dwell_cnt == DWELL_LAST);
    assign row_nxt   = row + 2'd1;

    // Lowest pending key is drained first, so simultaneous presses leave in code order.
    always_comb begin
        pending_low = pending & (~pending + 16'd1);
        push        = |pending;
        push_code   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) push_code = 4'(i);
        end
    end

    assign pop      = kp.key_pop && (level != '0);
    assign full     = (level == LVL_FULL);
    assign do_write = push && (!full || pop);

    // Debounce decision is taken the cycle after row 3 lands in the snapshot.
    always_comb begin
        stable_cnt_nxt = stable_cnt;
        accept         = 1'b0;
        if (scan_done) begin
            if (snapshot == prev_snapshot) begin
                stable_cnt_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;
            end else begin
                stable_cnt_nxt = '0;
            end
            accept = (stable_cnt_nxt == STABLE_MAX) && (stable_cnt != STABLE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_meta      <= 4'hF;
            col_sync      <= 4'hF;
            dwell_cnt     <= '0;
            row           <= 2'd0;
            filas         <= 4'b1110;
            scan_done     <= 1'b0;
            snapshot      <= '0;
            prev_snapshot <= '0;
            stable        <= '0;
            pending       <= '0;
            stable_cnt    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            ovf           <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            col_meta <= columnas;
            col_sync <= col_meta;

            // Sampling at the end of the dwell gives the row drive time to settle.
            if (dwell_end) begin
                dwell_cnt                 <= '0;
                snapshot[{row, 2'b00} +: 4] <= ~col_sync;
                row                       <= row_nxt;
                filas                     <= ~(4'b0001 << row_nxt);
            end else begin
                dwell_cnt <= dwell_cnt + DIV_W'(1);
            end
            scan_done <= dwell_end && (row == 2'd3);

            if (scan_done) begin
                stable_cnt    <= stable_cnt_nxt;
                prev_snapshot <= snapshot;
            end
            // Only keys that were released in the old stable view count as new presses.
            if (accept) stable <= snapshot;
            pending <= (pending & ~pending_low) | (accept ? (snapshot & ~stable) : 16'd0);

            if (do_write) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_write && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!do_write && pop) begin
                level <= level - LVL_W'(1);
            end

            // A drop in the same cycle as a clear wins, so no lost press goes unreported.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (kp.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign kp.key_code   = mem[rd_ptr];
    assign kp.key_valid  = (level != '0);
    assign kp.fifo_level = level;
    assign kp.overflow   = ovf;
    assign kp.irq        = (level != '0);
endmodule
